// File: rtl/need_engine_pkg.sv
// rtl/need_engine_pkg.sv - mode encodings and default channel roles for need_engine
// Shared by the need_engine top, its channel sub-module and the interface users.
package need_engine_pkg;

    typedef enum logic [1:0] {
        MODE_ACTIVE = 2'b00,
        MODE_SLEEP  = 2'b01,
        MODE_TEST   = 2'b10,
        MODE_DEAD   = 2'b11
    } mode_t;

    localparam int DEF_HEALTH_IDX = 0;
    localparam int DEF_ENERGY_IDX = 2;

endpackage

// File: rtl/need_engine_if.sv
// rtl/need_engine_if.sv - stimulus/status bundle between game logic and need_engine
// Ports (slave = engine side):
//   tick, action[NUM_NEEDS], sleep_btn, test_btn : pulses into the engine
//   levels[NUM_NEEDS*LEVEL_W], critical[NUM_NEEDS], worst_idx, mode : engine status
interface need_engine_if #(
    parameter int NUM_NEEDS = 5,
    parameter int LEVEL_W   = 3
);
    logic                          tick;
    logic [NUM_NEEDS-1:0]          action;
    logic                          sleep_btn;
    logic                          test_btn;
    logic [NUM_NEEDS*LEVEL_W-1:0]  levels;
    logic [NUM_NEEDS-1:0]          critical;
    logic [$clog2(NUM_NEEDS)-1:0]  worst_idx;
    logic [1:0]                    mode;

    modport master (
        output tick, action, sleep_btn, test_btn,
        input  levels, critical, worst_idx, mode
    );

    modport slave (
        input  tick, action, sleep_btn, test_btn,
        output levels, critical, worst_idx, mode
    );
endinterface

// File: rtl/need_engine_channel.sv
// rtl/need_engine_channel.sv - one need channel: decay prescaler plus saturating level
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   tick_en      : advance the prescaler this cycle
//   act          : action pulse (refill, or decrement when dec_mode)
//   dec_mode     : act decrements by one instead of refilling, prescaler untouched
//   inc_mode     : decay event raises the level instead of lowering it
//   load_max     : force level to MAX_LEVEL
//   level        : registered level
//   level_next   : combinational next level (used for look-ahead checks in the top)
module need_channel #(
    parameter int LEVEL_W     = 3,
    parameter int MAX_LEVEL   = 5,
    parameter int REFILL      = 2,
    parameter int DECAY_TICKS = 10,
    parameter int PRESET      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_en,
    input  logic               act,
    input  logic               dec_mode,
    input  logic               inc_mode,
    input  logic               load_max,
    output logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] level_next
);
    localparam int CNT_W = $clog2(DECAY_TICKS);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DECAY_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_PRESET = CNT_W'(PRESET);
    localparam logic [LEVEL_W-1:0] LV_MAX     = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W:0]   REFILL_V   = (LEVEL_W + 1)'(REFILL);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic             decay_ev;
    logic [LEVEL_W:0] refill_sum;

    always_comb begin
        decay_ev = tick_en && (cnt == CNT_LAST);
        cnt_next = cnt;
        if (tick_en)
            cnt_next = decay_ev ? '0 : cnt + 1'b1;
        // A refill restarts the decay period so a fed need gets a full interval.
        if (act && !dec_mode)
            cnt_next = '0;

        // Extra bit keeps level+REFILL from wrapping before the clamp.
        refill_sum = {1'b0, level} + REFILL_V;
        level_next = level;
        if (load_max) begin
            level_next = LV_MAX;
        end else if (act) begin
            if (dec_mode)
                level_next = (level == '0) ? level : level - 1'b1;
            else
                level_next = (refill_sum >= {1'b0, LV_MAX}) ? LV_MAX : refill_sum[LEVEL_W-1:0];
        end else if (decay_ev) begin
            if (inc_mode)
                level_next = (level >= LV_MAX) ? LV_MAX : level + 1'b1;
            else
                level_next = (level == '0) ? level : level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= CNT_PRESET;
            level <= LV_MAX;
        end else begin
            cnt   <= cnt_next;
            level <= level_next;
        end
    end
endmodule

// File: rtl/need_engine.sv
// rtl/need_engine.sv - parametrised need levels with decay/refill and ACTIVE/SLEEP/TEST/DEAD mode FSM
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : need_engine_if.slave (tick, action, sleep_btn, test_btn in;
//                levels, critical, worst_idx, mode out, all registered)
module need_engine
    import need_engine_pkg::*;
#(
    parameter int NUM_NEEDS   = 5,
    parameter int LEVEL_W     = 3,
    parameter int MAX_LEVEL   = 5,
    parameter int REFILL      = 2,
    parameter int DECAY_TICKS = 10,
    parameter int HEALTH_IDX  = DEF_HEALTH_IDX,
    parameter int ENERGY_IDX  = DEF_ENERGY_IDX,
    parameter int DEATH_ZEROS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    need_engine_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_NEEDS);
    localparam int ZC_W    = $clog2(NUM_NEEDS + 1);
    localparam int STAGGER = DECAY_TICKS / NUM_NEEDS;
    localparam logic [LEVEL_W-1:0] LV_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LV_CRIT = LEVEL_W'(1);
    localparam logic [ZC_W-1:0]    DZ      = ZC_W'(DEATH_ZEROS);

    mode_t                mode_q;
    logic [LEVEL_W-1:0]   lv      [NUM_NEEDS];
    logic [LEVEL_W-1:0]   lv_next [NUM_NEEDS];
    logic [NUM_NEEDS-1:0] act_v;
    logic                 tick_en, sleeping, in_test, load_max, death;
    logic [ZC_W-1:0]      zero_cnt;
    logic [IDX_W-1:0]     w_idx, worst_q;
    logic [LEVEL_W-1:0]   w_lv;
    logic [NUM_NEEDS-1:0] crit_c, crit_q;

    always_comb begin
        sleeping = (mode_q == MODE_SLEEP);
        in_test  = (mode_q == MODE_TEST);
        // Prescalers only run while time passes for the pet.
        tick_en  = bus.tick && (mode_q == MODE_ACTIVE || sleeping);
        act_v    = (mode_q == MODE_ACTIVE || in_test) ? bus.action : '0;
        load_max = in_test && bus.test_btn;
    end

    for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_ch
        need_channel #(
            .LEVEL_W     (LEVEL_W),
            .MAX_LEVEL   (MAX_LEVEL),
            .REFILL      (REFILL),
            .DECAY_TICKS (DECAY_TICKS),
            .PRESET      (g * STAGGER)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_en    (tick_en),
            .act        (act_v[g]),
            .dec_mode   (in_test),
            .inc_mode   (sleeping && (g == ENERGY_IDX)),
            .load_max   (load_max),
            .level      (lv[g]),
            .level_next (lv_next[g])
        );
        assign bus.levels[g*LEVEL_W +: LEVEL_W] = lv[g];
    end

    // Death looks at the levels about to be written, so DEAD and the fatal
    // level appear on the same clock edge.
    always_comb begin
        zero_cnt = '0;
        for (int i = 0; i < NUM_NEEDS; i++)
            zero_cnt = zero_cnt + ZC_W'(lv_next[i] == '0);
        death = (lv_next[HEALTH_IDX] == '0) || (zero_cnt >= DZ);
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_idx = '0;
        w_lv  = lv[0];
        for (int i = 1; i < NUM_NEEDS; i++) begin
            if (lv[i] < w_lv) begin
                w_lv  = lv[i];
                w_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_NEEDS; i++)
            crit_c[i] = (lv[i] <= LV_CRIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_ACTIVE;
            crit_q  <= '0;
            worst_q <= '0;
        end else begin
            crit_q  <= crit_c;
            worst_q <= w_idx;
            case (mode_q)
                MODE_ACTIVE: begin
                    if (death)              mode_q <= MODE_DEAD;
                    else if (bus.test_btn)  mode_q <= MODE_TEST;
                    else if (bus.sleep_btn) mode_q <= MODE_SLEEP;
                end
                MODE_SLEEP: begin
                    if (death)
                        mode_q <= MODE_DEAD;
                    else if (bus.sleep_btn || lv_next[ENERGY_IDX] == LV_MAX)
                        mode_q <= MODE_ACTIVE;
                end
                MODE_TEST: begin
                    if (bus.test_btn) mode_q <= MODE_ACTIVE;
                end
                default: mode_q <= mode_q;
            endcase
        end
    end

    assign bus.mode      = mode_q;
    assign bus.critical  = crit_q;
    assign bus.worst_idx = worst_q;
endmodule

// File: tb/tb_need_engine.sv
// tb/tb_need_engine.sv - self-checking bench for need_engine against a behavioural model
module tb_need_engine;
    import need_engine_pkg::*;

    localparam int N    = 5;
    localparam int W    = 3;
    localparam int MAXL = 5;
    localparam int DT   = 10;
    localparam logic [N*W-1:0] ALL_MAX = {N{3'd5}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    need_engine_if #(.NUM_NEEDS(N), .LEVEL_W(W)) bus ();

    need_engine #(
        .NUM_NEEDS(N), .LEVEL_W(W), .MAX_LEVEL(MAXL), .REFILL(2), .DECAY_TICKS(DT),
        .HEALTH_IDX(0), .ENERGY_IDX(2), .DEATH_ZEROS(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: need levels, ticks elapsed in each channel's current decay period, mode.
    int           m_lv [N];
    int           m_ph [N];
    int           m_mode;
    logic [N-1:0] e_crit;
    int           e_worst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int lvl(input int i);
        return int'(bus.levels[i*W +: W]);
    endfunction

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lv[i] = MAXL;
            m_ph[i] = i * (DT / N);
        end
        m_mode  = 0;
        e_crit  = '0;
        e_worst = 0;
    endtask

    task automatic model_step(input bit t, input logic [N-1:0] a, input bit sb, input bit tb_);
        int  nl [N];
        bit  ev [N];
        int  zeros;
        bit  alive;
        alive = (m_mode == 0 || m_mode == 1);
        // Status flags reflect the levels held before this edge.
        e_worst = 0;
        for (int i = 0; i < N; i++) begin
            e_crit[i] = (m_lv[i] <= 1);
            if (m_lv[i] < m_lv[e_worst]) e_worst = i;
        end
        for (int i = 0; i < N; i++) begin
            nl[i] = m_lv[i];
            ev[i] = 1'b0;
            if (alive && t) begin
                m_ph[i] = m_ph[i] + 1;
                if (m_ph[i] == DT) begin
                    m_ph[i] = 0;
                    ev[i]   = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            case (m_mode)
                0: if (a[i]) begin
                       nl[i]   = mn(m_lv[i] + 2, MAXL);
                       m_ph[i] = 0;
                   end else if (ev[i]) nl[i] = mx(m_lv[i] - 1, 0);
                1: if (ev[i]) nl[i] = (i == 2) ? mn(m_lv[i] + 1, MAXL) : mx(m_lv[i] - 1, 0);
                2: if (a[i]) nl[i] = mx(m_lv[i] - 1, 0);
                default: ;
            endcase
        end
        zeros = 0;
        for (int i = 0; i < N; i++) if (nl[i] == 0) zeros++;
        if (alive && (nl[0] == 0 || zeros >= 3)) m_mode = 3;
        else if (m_mode == 0 && tb_)              m_mode = 2;
        else if (m_mode == 0 && sb)               m_mode = 1;
        else if (m_mode == 1 && (sb || nl[2] == MAXL)) m_mode = 0;
        else if (m_mode == 2 && tb_) begin
            m_mode = 0;
            for (int i = 0; i < N; i++) nl[i] = MAXL;
        end
        for (int i = 0; i < N; i++) m_lv[i] = nl[i];
    endtask

    task automatic check_all(input string tag);
        logic [N*W-1:0] exp_lv;
        for (int i = 0; i < N; i++) exp_lv[i*W +: W] = W'(m_lv[i]);
        chk({tag, "_levels"}, 32'(bus.levels), 32'(exp_lv));
        chk({tag, "_mode"}, 32'(bus.mode), 32'(m_mode));
        chk({tag, "_critical"}, 32'(bus.critical), 32'(e_crit));
        chk({tag, "_worst"}, 32'(bus.worst_idx), 32'(e_worst));
    endtask

    task automatic step(input bit t, input logic [N-1:0] a, input bit sb, input bit tb_);
        bus.tick = t; bus.action = a; bus.sleep_btn = sb; bus.test_btn = tb_;
        @(posedge clk);
        model_step(t, a, sb, tb_);
        #1;
        bus.tick = 1'b0; bus.action = '0; bus.sleep_btn = 1'b0; bus.test_btn = 1'b0;
        check_all("step");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        check_all("reset");
    endtask

    initial begin
        int n4, guard;
        bus.tick = 1'b0; bus.action = '0; bus.sleep_btn = 1'b0; bus.test_btn = 1'b0;

        // Reset values
        do_reset();
        chk("reset_levels_const", 32'(bus.levels), 32'(ALL_MAX));
        chk("reset_mode_const", 32'(bus.mode), 32'(MODE_ACTIVE));

        // Staggered decay: one channel drops on every even tick
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, '0, 1'b0, 1'b0);
            n4 = 0;
            for (int i = 0; i < N; i++) if (lvl(i) == 4) n4++;
            chk("stagger_count", 32'(n4), 32'(k / 2));
        end
        chk("stagger_final", 32'(bus.levels), 32'({N{3'd4}}));

        // Refill saturates at MAX
        step(1'b0, 5'b00001, 1'b0, 1'b0);
        chk("refill_sat", 32'(lvl(0)), 32'd5);

        // Level 1 with action coinciding with a decay event -> 3
        do_reset();
        guard = 0;
        while (m_lv[4] != 1 && guard < 40) begin
            step(1'b1, 5'b01111, 1'b0, 1'b0);
            guard++;
        end
        chk("refill_reach1", 32'(lvl(4)), 32'd1);
        guard = 0;
        while (m_ph[4] != DT - 1 && guard < 12) begin
            step(1'b1, 5'b01111, 1'b0, 1'b0);
            guard++;
        end
        step(1'b1, 5'b11111, 1'b0, 1'b0);
        chk("refill_vs_decay", 32'(lvl(4)), 32'd3);

        // Sleep: energy recovers, actions ignored, auto-wake at MAX
        do_reset();
        guard = 0;
        while (m_lv[2] != 3 && guard < 30) begin
            step(1'b1, 5'b11011, 1'b0, 1'b0);
            guard++;
        end
        chk("sleep_energy3", 32'(lvl(2)), 32'd3);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("sleep_enter", 32'(bus.mode), 32'(MODE_SLEEP));
        guard = 0;
        while (m_lv[2] != 4 && guard < 15) begin
            step(1'b1, N'($urandom), 1'b0, 1'b0);
            guard++;
        end
        chk("sleep_energy4", 32'(lvl(2)), 32'd4);
        chk("sleep_still", 32'(bus.mode), 32'(MODE_SLEEP));
        guard = 0;
        while (m_mode != 0 && guard < 15) begin
            step(1'b1, N'($urandom), 1'b0, 1'b0);
            guard++;
        end
        chk("sleep_wake_mode", 32'(bus.mode), 32'(MODE_ACTIVE));
        chk("sleep_wake_energy", 32'(lvl(2)), 32'd5);

        // Death by health channel, then frozen
        do_reset();
        guard = 0;
        while (m_mode != 3 && guard < 60) begin
            step(1'b1, 5'b11110, 1'b0, 1'b0);
            guard++;
        end
        chk("death_health_mode", 32'(bus.mode), 32'(MODE_DEAD));
        chk("death_health_lv", 32'(lvl(0)), 32'd0);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, N'($urandom), 1'($urandom), 1'($urandom));
            chk("dead_hold_mode", 32'(bus.mode), 32'(MODE_DEAD));
            chk("dead_hold_lv", 32'(lvl(0)), 32'd0);
        end
        do_reset();
        chk("dead_reset", 32'(bus.levels), 32'(ALL_MAX));

        // Death by three zero channels
        guard = 0;
        while (m_mode != 3 && guard < 70) begin
            step(1'b1, 5'b00011, 1'b0, 1'b0);
            guard++;
        end
        chk("death_zeros_mode", 32'(bus.mode), 32'(MODE_DEAD));
        chk("death_zeros_health", 32'(lvl(0)), 32'd5);

        // Test mode
        do_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        chk("test_enter", 32'(bus.mode), 32'(MODE_TEST));
        for (int k = 0; k < 40; k++) step(1'b1, '0, 1'($urandom_range(0, 3) == 0), 1'b0);
        chk("test_hold", 32'(bus.levels), 32'(ALL_MAX));
        step(1'b0, 5'b00010, 1'b0, 1'b0);
        step(1'b0, 5'b00010, 1'b0, 1'b0);
        chk("test_dec", 32'(lvl(1)), 32'd3);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("test_exit_mode", 32'(bus.mode), 32'(MODE_ACTIVE));
        chk("test_exit_lv", 32'(bus.levels), 32'(ALL_MAX));

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (m_mode == 3 && $urandom_range(0, 3) == 0)
                do_reset();
            else
                step(1'($urandom), ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
